// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of requester and memory-side signals for cpu_mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters and memory macro.
interface cpu_mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic [2:0]          req;
   logic [2:0]          we;
   logic [3*ADDR_W-1:0] addr;
   logic [3*DATA_W-1:0] wdata;
   logic                dbg_lock;
   logic [2:0]          gnt;
   logic [2:0]          rvalid;
   logic [DATA_W-1:0]   rdata;
   logic                mem_en;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;

   modport slave (
      input  req, we, addr, wdata, dbg_lock, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr, wdata, dbg_lock, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between CPU data, CPU fetch and debug.
// It tracks in-flight reads through the fixed memory latency and returns each read to the port that issued it.
module cpu_mem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1
) (
   input logic              clk,
   input logic              rst_n,
   cpu_mem_arbiter_if.slave bus
);

   logic [1:0]          last;
   logic [2:0]          eligible;
   logic [1:0]          first_p;
   logic [1:0]          second_p;
   logic [1:0]          third_p;
   logic [1:0]          winner;
   logic                grant_any;
   logic                winner_we;
   logic [ADDR_W-1:0]   winner_addr;
   logic [DATA_W-1:0]   winner_wdata;

   logic [READ_LAT-1:0] pipe_valid;
   logic [1:0]          pipe_port [READ_LAT];

   // The search starts just after the last winner. The unused code 3 behaves like 2.
   always_comb begin
      first_p  = 2'd0;
      second_p = 2'd1;
      third_p  = 2'd2;
      case (last)
         2'd0: begin
            first_p  = 2'd1;
            second_p = 2'd2;
            third_p  = 2'd0;
         end
         2'd1: begin
            first_p  = 2'd2;
            second_p = 2'd0;
            third_p  = 2'd1;
         end
         default: begin
            first_p  = 2'd0;
            second_p = 2'd1;
            third_p  = 2'd2;
         end
      endcase
   end

   // While in reset, nothing is eligible. This keeps gnt, mem_en and mem_we low whatever req does.
   always_comb begin
      eligible  = bus.req & (bus.dbg_lock ? 3'b100 : 3'b111);
      if (!rst_n) begin
         eligible = 3'b000;
      end
      grant_any = 1'b0;
      winner    = 2'd0;
      if (eligible[first_p]) begin
         grant_any = 1'b1;
         winner    = first_p;
      end else if (eligible[second_p]) begin
         grant_any = 1'b1;
         winner    = second_p;
      end else if (eligible[third_p]) begin
         grant_any = 1'b1;
         winner    = third_p;
      end
   end

   always_comb begin
      winner_we    = bus.we[winner];
      winner_addr  = bus.addr[winner*ADDR_W +: ADDR_W];
      winner_wdata = bus.wdata[winner*DATA_W +: DATA_W];
   end

   // With no grant, the memory bus is driven to zero rather than holding the previous access.
   always_comb begin
      bus.gnt       = 3'b000;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (grant_any) begin
         bus.gnt       = 3'b001 << winner;
         bus.mem_en    = 1'b1;
         bus.mem_we    = winner_we;
         bus.mem_addr  = winner_addr;
         bus.mem_wdata = winner_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 2'd2;
      end else if (grant_any) begin
         last <= winner;
      end
   end

   // Each pipeline stage holds whether a read is in flight and which port it belongs to.
   // The pipeline shifts every cycle and never stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid <= '0;
         for (int s = 0; s < READ_LAT; s++) begin
            pipe_port[s] <= 2'd0;
         end
      end else begin
         pipe_valid[0] <= grant_any & ~winner_we;
         pipe_port[0]  <= winner;
         for (int s = 1; s < READ_LAT; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_port[s]  <= pipe_port[s-1];
         end
      end
   end

   // The last stage lines up with mem_rdata, so the return is registered on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rvalid <= 3'b000;
         bus.rdata  <= '0;
      end else begin
         bus.rvalid <= pipe_valid[READ_LAT-1] ? (3'b001 << pipe_port[READ_LAT-1]) : 3'b000;
         if (pipe_valid[READ_LAT-1]) begin
            bus.rdata <= bus.mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter. It drives identical requests into a READ_LAT=1 and a READ_LAT=3 instance.
// Each instance has its own memory model, and a queue-based reference model checks both instances.
module tb_cpu_mem_arbiter;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [2:0]          req;
   logic [2:0]          we;
   logic [3*ADDR_W-1:0] addr;
   logic [3*DATA_W-1:0] wdata;
   logic                dbg_lock;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   cpu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
   cpu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

   assign bus1.req = req;
   assign bus1.we = we;
   assign bus1.addr = addr;
   assign bus1.wdata = wdata;
   assign bus1.dbg_lock = dbg_lock;
   assign bus3.req = req;
   assign bus3.we = we;
   assign bus3.addr = addr;
   assign bus3.wdata = wdata;
   assign bus3.dbg_lock = dbg_lock;

   cpu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );
   cpu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3)
   );

   // Synchronous memory macros with read latencies of 1 and 3.
   logic [15:0] mem1 [256];
   logic [15:0] mem3 [256];
   logic [15:0] rp1;
   logic [15:0] rp3 [3];
   assign bus1.mem_rdata = rp1;
   assign bus3.mem_rdata = rp3[2];

   always @(posedge clk) begin
      if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
      if (bus1.mem_en && !bus1.mem_we) rp1 <= mem1[bus1.mem_addr];
   end

   always @(posedge clk) begin
      if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr] <= bus3.mem_wdata;
      if (bus3.mem_en && !bus3.mem_we) rp3[0] <= mem3[bus3.mem_addr];
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
   end

   // Reference model: the last winner, a memory image, and queues of pending returns with due cycles.
   typedef struct {
      int          due;
      logic [1:0]  port;
      logic [15:0] data;
   } ret_t;

   ret_t        q1[$];
   ret_t        q3[$];
   int          m_last = 2;
   logic [15:0] m_mem [256];
   logic [15:0] m_rd1 = 16'h0;
   logic [15:0] m_rd3 = 16'h0;
   int          cyc = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : compare
      logic [2:0]  elig;
      logic [2:0]  egnt;
      logic [2:0]  erv;
      logic [7:0]  eaddr;
      logic [15:0] ewd;
      logic        ewe;
      int          win;
      if (!rst_n) begin
         q1.delete();
         q3.delete();
         m_last = 2;
         m_rd1  = 16'h0;
         m_rd3  = 16'h0;
         check_output("rst_gnt1", bus1.gnt, 0);
         check_output("rst_en1", bus1.mem_en, 0);
         check_output("rst_we1", bus1.mem_we, 0);
         check_output("rst_rvalid1", bus1.rvalid, 0);
         check_output("rst_rdata1", bus1.rdata, 0);
         check_output("rst_gnt3", bus3.gnt, 0);
         check_output("rst_en3", bus3.mem_en, 0);
         check_output("rst_rvalid3", bus3.rvalid, 0);
         check_output("rst_rdata3", bus3.rdata, 0);
      end else begin
         elig = req & (dbg_lock ? 3'b100 : 3'b111);
         win  = -1;
         for (int k = 0; k < 3; k++) begin
            if (win < 0 && elig[(m_last + 1 + k) % 3]) win = (m_last + 1 + k) % 3;
         end
         egnt  = (win < 0) ? 3'b000 : 3'(1 << win);
         eaddr = (win < 0) ? 8'h00 : addr[win*ADDR_W +: ADDR_W];
         ewd   = (win < 0) ? 16'h0 : wdata[win*DATA_W +: DATA_W];
         ewe   = (win < 0) ? 1'b0 : we[win];
         check_output("gnt1", bus1.gnt, egnt);
         check_output("gnt3", bus3.gnt, egnt);
         check_output("mem_en1", bus1.mem_en, (win >= 0));
         check_output("mem_en3", bus3.mem_en, (win >= 0));
         check_output("mem_we1", bus1.mem_we, ewe);
         check_output("mem_we3", bus3.mem_we, ewe);
         check_output("mem_addr1", bus1.mem_addr, eaddr);
         check_output("mem_addr3", bus3.mem_addr, eaddr);
         check_output("mem_wdata1", bus1.mem_wdata, ewd);
         check_output("mem_wdata3", bus3.mem_wdata, ewd);

         erv = 3'b000;
         if (q1.size() > 0 && q1[0].due == cyc) begin
            erv   = 3'(1 << q1[0].port);
            m_rd1 = q1[0].data;
            void'(q1.pop_front());
         end
         check_output("rvalid1", bus1.rvalid, erv);
         check_output("rdata1", bus1.rdata, m_rd1);

         erv = 3'b000;
         if (q3.size() > 0 && q3[0].due == cyc) begin
            erv   = 3'(1 << q3[0].port);
            m_rd3 = q3[0].data;
            void'(q3.pop_front());
         end
         check_output("rvalid3", bus3.rvalid, erv);
         check_output("rdata3", bus3.rdata, m_rd3);

         if (win >= 0) begin
            m_last = win;
            if (ewe) begin
               m_mem[eaddr] = ewd;
            end else begin
               q1.push_back('{due: cyc + 2, port: 2'(win), data: m_mem[eaddr]});
               q3.push_back('{due: cyc + 4, port: 2'(win), data: m_mem[eaddr]});
            end
         end
      end
      cyc++;
   end

   task automatic apply_stimulus(input logic [2:0] r, input logic [2:0] w, input logic [7:0] a0,
                                 input logic [7:0] a1, input logic [7:0] a2, input logic [15:0] d0,
                                 input logic lock);
      req      = r;
      we       = w;
      addr     = {a2, a1, a0};
      wdata    = {16'h0, 16'h0, d0};
      dbg_lock = lock;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] rr_seq [6];
   logic [2:0] g;

   initial begin
      for (int a = 0; a < 256; a++) begin
         mem1[a]  = {8'(a), 8'(a) ^ 8'hFF};
         mem3[a]  = {8'(a), 8'(a) ^ 8'hFF};
         m_mem[a] = {8'(a), 8'(a) ^ 8'hFF};
      end
      rp1 = 16'h0;
      for (int s = 0; s < 3; s++) rp3[s] = 16'h0;
      rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      // Reset with all requests high, so grants must stay off.
      rst_n = 1'b0;
      apply_stimulus(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 16'h0, 1'b0);
      @(negedge clk);
      check_output("plan_rst_gnt", bus1.gnt, 3'b000);
      check_output("plan_rst_en", bus1.mem_en, 0);
      next_cycle();
      rst_n = 1'b1;

      // All three ports read continuously, so grants rotate and returns follow.
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_output("plan_rr_gnt", bus1.gnt, rr_seq[c]);
         if (c == 2) begin
            check_output("plan_rr_rv1a", bus1.rvalid, 3'b001);
            check_output("plan_rr_rd1a", bus1.rdata, 16'h10EF);
         end
         if (c == 3) begin
            check_output("plan_rr_rv1b", bus1.rvalid, 3'b010);
            check_output("plan_rr_rd1b", bus1.rdata, 16'h20DF);
         end
         if (c == 4) begin
            check_output("plan_rr_rv1c", bus1.rvalid, 3'b100);
            check_output("plan_rr_rd1c", bus1.rdata, 16'h30CF);
            check_output("plan_rr_rv3a", bus3.rvalid, 3'b001);
            check_output("plan_rr_rd3a", bus3.rdata, 16'h10EF);
         end
         next_cycle();
      end
      apply_stimulus(3'b000, 3'b000, 8'h0, 8'h0, 8'h0, 16'h0, 1'b0);
      repeat (8) next_cycle();

      // Port 0 writes, then port 1 reads the same address.
      apply_stimulus(3'b001, 3'b001, 8'h05, 8'h00, 8'h00, 16'hBEEF, 1'b0);
      @(negedge clk);
      check_output("plan_wr_gnt", bus1.gnt, 3'b001);
      check_output("plan_wr_we", bus1.mem_we, 1);
      check_output("plan_wr_wdata", bus1.mem_wdata, 16'hBEEF);
      next_cycle();
      apply_stimulus(3'b010, 3'b000, 8'h00, 8'h05, 8'h00, 16'h0, 1'b0);
      @(negedge clk);
      check_output("plan_rd_gnt", bus1.gnt, 3'b010);
      check_output("plan_rd_we", bus1.mem_we, 0);
      check_output("plan_rd_addr", bus1.mem_addr, 8'h05);
      next_cycle();
      apply_stimulus(3'b000, 3'b000, 8'h0, 8'h0, 8'h0, 16'h0, 1'b0);
      @(negedge clk);
      check_output("plan_wr_norv", bus1.rvalid, 3'b000);
      next_cycle();
      @(negedge clk);
      check_output("plan_rd_rv", bus1.rvalid, 3'b010);
      check_output("plan_rd_data", bus1.rdata, 16'hBEEF);
      next_cycle();
      repeat (6) next_cycle();

      // With dbg_lock set, only port 2 may be granted. After unlock, port 0 wins because last is 2.
      apply_stimulus(3'b111, 3'b000, 8'h40, 8'h41, 8'h42, 16'h0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_output("plan_lock_gnt", bus1.gnt, 3'b100);
         next_cycle();
      end
      dbg_lock = 1'b0;
      @(negedge clk);
      check_output("plan_unlock_gnt", bus1.gnt, 3'b001);
      next_cycle();
      apply_stimulus(3'b000, 3'b000, 8'h0, 8'h0, 8'h0, 16'h0, 1'b0);
      repeat (8) next_cycle();

      // A read is granted and reset is pulsed in the next cycle. The read must never return.
      apply_stimulus(3'b010, 3'b000, 8'h00, 8'h07, 8'h00, 16'h0, 1'b0);
      @(negedge clk);
      check_output("plan_kill_gnt", bus1.gnt, 3'b010);
      next_cycle();
      rst_n = 1'b0;
      req   = 3'b000;
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_output("plan_kill_rv1", bus1.rvalid, 3'b000);
         check_output("plan_kill_rv3", bus3.rvalid, 3'b000);
         check_output("plan_kill_en", bus1.mem_en, 0);
         next_cycle();
      end

      // Back-to-back reads from port 2 on the READ_LAT=3 instance.
      for (int c = 0; c < 8; c++) begin
         if (c < 4) apply_stimulus(3'b100, 3'b000, 8'h0, 8'h0, 8'(c), 16'h0, 1'b0);
         else apply_stimulus(3'b000, 3'b000, 8'h0, 8'h0, 8'h0, 16'h0, 1'b0);
         @(negedge clk);
         if (c < 4) begin
            check_output("plan_lat3_gnt", bus3.gnt, 3'b100);
         end else begin
            check_output("plan_lat3_rv", bus3.rvalid, 3'b100);
            check_output("plan_lat3_rd", bus3.rdata, {8'(c - 4), 8'(c - 4) ^ 8'hFF});
         end
         next_cycle();
      end
      repeat (4) next_cycle();

      // A port 0 request is withdrawn while port 2 is granted. last must stay 2, so port 0 wins next.
      apply_stimulus(3'b101, 3'b000, 8'h55, 8'h00, 8'h66, 16'h0, 1'b1);
      @(negedge clk);
      check_output("plan_wd_gnt", bus1.gnt, 3'b100);
      check_output("plan_wd_addr", bus1.mem_addr, 8'h66);
      next_cycle();
      apply_stimulus(3'b000, 3'b000, 8'h55, 8'h00, 8'h66, 16'h0, 1'b0);
      @(negedge clk);
      check_output("plan_wd_idle_en", bus1.mem_en, 0);
      check_output("plan_wd_idle_addr", bus1.mem_addr, 8'h00);
      next_cycle();
      apply_stimulus(3'b011, 3'b000, 8'h55, 8'h56, 8'h00, 16'h0, 1'b0);
      @(negedge clk);
      check_output("plan_wd_next", bus1.gnt, 3'b001);
      next_cycle();
      apply_stimulus(3'b000, 3'b000, 8'h0, 8'h0, 8'h0, 16'h0, 1'b0);
      repeat (6) next_cycle();

      // Random traffic. Pending requests are held until granted, may be withdrawn, and reset is pulsed now and then.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         g = bus1.gnt;
         next_cycle();
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (!req[i] || g[i]) begin
               req[i]                    = ($urandom_range(0, 2) != 0);
               we[i]                     = ($urandom_range(0, 2) == 0);
               addr[i*ADDR_W +: ADDR_W]  = 8'($urandom_range(0, 15));
               wdata[i*DATA_W +: DATA_W] = 16'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
               req[i] = 1'b0;
            end
         end
         if ($urandom_range(0, 19) == 0) dbg_lock = ~dbg_lock;
      end
      apply_stimulus(3'b000, 3'b000, 8'h0, 8'h0, 8'h0, 16'h0, 1'b0);
      rst_n = 1'b1;
      repeat (8) next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
